coreaxi4sram_wrctrl: RTL
========================

Name: coreaxi4sram_wrctrl

Overview:
Write-channel controller in the CoreAXI4SRAM main-control layer, directly downstream of the slave interface. It consumes the slave interface's registered AW fields and pass-through W signals, and returns the address-capture strobe and ready signals to it. It generates per-beat SRAM write strobes with FIXED/INCR/WRAP address sequencing, then returns the write response.

Parameters:
AXI4_DWIDTH, 64, data width in bits (32/64); BYTES = AXI4_DWIDTH/8, BSH = log2(BYTES)
AXI4_AWIDTH, 32, AXI address width
AXI4_IDWIDTH, 4, ID width
MEM_DEPTH, 512, SRAM depth in words; localparam MEM_AW = clog2(MEM_DEPTH)
AXI4_IFTYPE_WR, 1, 0 = write path disabled (awready_mc/wready_mc tied 0, FSM held IDLE)

Ports:
ACLK  in  1  clock
ARESETN  in  1  async active-low reset
AWID_slvif  in  IDWIDTH  registered AW ID
AWVALID_slvif  in  1  AW valid (pass-through)
AWADDR_slvif  in  AWIDTH  registered byte address
AWLEN_slvif  in  8  registered burst length-1
AWSIZE_slvif  in  3  registered beat size
AWBURST_slvif  in  2  registered burst type
WDATA_slvif  in  DWIDTH  write data
WSTRB_slvif  in  BYTES  byte strobes
WLAST_slvif  in  1  last beat
WVALID_slvif  in  1  W valid
BREADY_S  in  1  master B ready
waddrchset_mc  out  1  AW capture strobe to slave interface
awready_mc  out  1  AW ready
wready_mc  out  1  W ready
bvalid_mc  out  1  B valid
bid_mc  out  IDWIDTH  B ID
bresp_mc  out  2  B response
mem_we  out  1  SRAM write enable, one cycle per beat
mem_waddr  out  MEM_AW  SRAM word address
mem_wdata  out  DWIDTH  SRAM write data
mem_wben  out  BYTES  SRAM byte enables

Behaviour:
- Reset: state IDLE; all outputs 0; counters and error flag cleared. A reset mid-burst aborts the burst, leaves no pending mem_we, and issues no B response.
- FSM states: IDLE, SETUP, WDATA, BRESP.
- IDLE: awready_mc = 1 and waddrchset_mc = AWVALID_slvif & awready_mc (combinational). On a handshake, go to SETUP. The slave interface registers the AW fields on the same edge.
- SETUP (one cycle, AW fields now valid):
  - load byte_addr = AWADDR_slvif and beats_left = AWLEN_slvif;
  - compute wrap_mask = ((AWLEN+1) << AWSIZE) - 1;
  - err = 1 if AWBURST == 2'b11 (then treated as INCR), AWSIZE > BSH, or WRAP with AWLEN not in {1,3,7,15};
  - capture bid_mc = AWID_slvif; go to WDATA.
- WDATA: wready_mc = 1. Each beat where WVALID & wready:
  - next cycle mem_we = 1 with mem_waddr = byte_addr[BSH+MEM_AW-1:BSH], mem_wdata = WDATA, mem_wben = WSTRB;
  - if word address >= MEM_DEPTH or any byte_addr bit above BSH+MEM_AW-1 is set: err = 1 and mem_we stays 0 for that beat;
  - address update: FIXED holds; INCR byte_addr += 1<<AWSIZE; WRAP byte_addr = (byte_addr & ~wrap_mask) | ((byte_addr + (1<<AWSIZE)) & wrap_mask);
  - beats_left decrements; on the beat where beats_left == 0 go to BRESP, wready_mc drops the next cycle;
  - WLAST mismatch (WLAST=1 with beats_left != 0, or WLAST=0 with beats_left == 0) sets err; the burst length is governed solely by AWLEN.
- BRESP: bvalid_mc = 1, bresp_mc = err ? 2'b10 (SLVERR) : 2'b00. Held stable until BREADY_S, then IDLE with bvalid_mc = 0 the next cycle.
- awready_mc is 0 outside IDLE, so there is a single outstanding write.
- Latency: AW handshake to first wready = 2 cycles. W beat to mem_we = 1 cycle. Last beat to bvalid = 1 cycle.
- Back-to-back: the earliest next AW handshake is the cycle after the BREADY handshake.
- Narrow transfers: WSTRB is forwarded unchanged; strobes are not masked.

Decomposition:
- Shared package coreaxi4sram_pkg holds burst encodings (FIXED=0, INCR=1, WRAP=2), response codes (OKAY=2'b00, SLVERR=2'b10) and FSM state encodings.
- One sub-module, coreaxi4sram_burst_addr: combinational next-address from (byte_addr, AWSIZE, AWBURST, wrap_mask). It is reused by the future read controller.

Test Plan:
- INCR, AWADDR=0x40, AWLEN=3, AWSIZE=3, DWIDTH=64 -> mem_waddr 8,9,10,11 with mem_we one cycle each; BRESP=00, bid echoes AWID=5.
- WRAP, AWADDR=0x38, AWLEN=3, AWSIZE=3 -> mem_waddr 7,4,5,6; BRESP=00.
- FIXED, AWADDR=0x10, AWLEN=2 with WSTRB 0x0F,0xF0,0xFF -> mem_waddr 2,2,2 carrying those mem_wben values.
- INCR, AWADDR=(MEM_DEPTH-1)*8, AWLEN=1 -> first beat written, second suppressed; BRESP=10.
- WLAST asserted on beat 1 of AWLEN=3 -> all 4 beats written; BRESP=10. BREADY held low 5 cycles -> bvalid/bresp stable, awready_mc stays 0.
- ARESETN pulsed low during beat 2 -> all outputs 0; a new AW is accepted cleanly with no stale mem_we or bvalid.

Source files
------------

// File: rtl/coreaxi4sram_pkg.sv
// Shared encodings for the CoreAXI4SRAM main-control layer: burst types, responses, FSM states.
package coreaxi4sram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_BRESP = 2'd3;

    // AXI4 only allows WRAP bursts of 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/coreaxi4sram_burst_addr.sv
// Next beat byte address for FIXED / INCR / WRAP bursts.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to advance.
module coreaxi4sram_burst_addr
    import coreaxi4sram_pkg::*;
#(
    parameter int AXI4_AWIDTH = 32
) (
    input  logic [AXI4_AWIDTH-1:0] byte_addr,
    input  logic [2:0]             size,
    input  logic [1:0]             burst,
    input  logic [AXI4_AWIDTH-1:0] wrap_mask,
    output logic [AXI4_AWIDTH-1:0] next_addr
);

    localparam logic [AXI4_AWIDTH-1:0] ONE = 1;

    logic [AXI4_AWIDTH-1:0] step;
    logic [AXI4_AWIDTH-1:0] incr_addr;

    assign step      = ONE << size;
    assign incr_addr = byte_addr + step;

    // Reserved burst is mapped to INCR by the caller, so default covers INCR.
    always_comb begin
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = byte_addr;
            BURST_WRAP:  next_addr = (byte_addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/coreaxi4sram_wrctrl.sv
// AXI4 write-channel controller: AW capture, per-beat SRAM writes, B response.
// Latency: AW handshake to wready 2 cycles, W beat to mem_we 1 cycle, last beat to bvalid 1 cycle.
// Backpressure: single outstanding write; awready low outside IDLE, bvalid held until BREADY_S.
module coreaxi4sram_wrctrl
    import coreaxi4sram_pkg::*;
#(
    parameter int AXI4_DWIDTH    = 64,
    parameter int AXI4_AWIDTH    = 32,
    parameter int AXI4_IDWIDTH   = 4,
    parameter int MEM_DEPTH      = 512,
    parameter int AXI4_IFTYPE_WR = 1,
    localparam int BYTES  = AXI4_DWIDTH / 8,
    localparam int MEM_AW = $clog2(MEM_DEPTH)
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [AXI4_IDWIDTH-1:0] AWID_slvif,
    input  logic                    AWVALID_slvif,
    input  logic [AXI4_AWIDTH-1:0]  AWADDR_slvif,
    input  logic [7:0]              AWLEN_slvif,
    input  logic [2:0]              AWSIZE_slvif,
    input  logic [1:0]              AWBURST_slvif,
    input  logic [AXI4_DWIDTH-1:0]  WDATA_slvif,
    input  logic [BYTES-1:0]        WSTRB_slvif,
    input  logic                    WLAST_slvif,
    input  logic                    WVALID_slvif,
    input  logic                    BREADY_S,
    output logic                    waddrchset_mc,
    output logic                    awready_mc,
    output logic                    wready_mc,
    output logic                    bvalid_mc,
    output logic [AXI4_IDWIDTH-1:0] bid_mc,
    output logic [1:0]              bresp_mc,
    output logic                    mem_we,
    output logic [MEM_AW-1:0]       mem_waddr,
    output logic [AXI4_DWIDTH-1:0]  mem_wdata,
    output logic [BYTES-1:0]        mem_wben
);

    localparam int BSH     = $clog2(BYTES);
    localparam int TOP_LSB = BSH + MEM_AW;
    localparam logic [2:0]             MAX_SIZE = 3'(BSH);
    localparam logic [MEM_AW:0]        DEPTH_W  = (MEM_AW + 1)'(MEM_DEPTH);
    localparam logic [AXI4_AWIDTH-1:0] ONE      = 1;
    localparam bit WR_EN = (AXI4_IFTYPE_WR != 0);

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic                   awready_q;
    logic [AXI4_AWIDTH-1:0] byte_addr;
    logic [AXI4_AWIDTH-1:0] wrap_mask;
    logic [AXI4_AWIDTH-1:0] next_addr;
    logic [7:0]             beats_left;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic                   err;

    logic                   w_beat;
    logic [MEM_AW-1:0]      word_addr;
    logic                   addr_hi_set;
    logic                   in_range;
    logic                   wlast_bad;
    logic                   setup_err;

    assign awready_mc    = awready_q;
    assign waddrchset_mc = AWVALID_slvif & awready_q;
    assign wready_mc     = (state == ST_WDATA);
    assign bvalid_mc     = (state == ST_BRESP);
    assign bresp_mc      = ((state == ST_BRESP) && err) ? RESP_SLVERR : RESP_OKAY;

    assign w_beat      = WVALID_slvif & wready_mc;
    assign word_addr   = byte_addr[TOP_LSB-1:BSH];
    assign addr_hi_set = (byte_addr >> TOP_LSB) != '0;
    assign in_range    = !addr_hi_set && ({1'b0, word_addr} < DEPTH_W);
    // Burst length is owned by AWLEN; WLAST only contributes to the error flag.
    assign wlast_bad   = WLAST_slvif ^ (beats_left == 8'd0);

    assign setup_err = (AWBURST_slvif == BURST_RSVD) ||
                       (AWSIZE_slvif > MAX_SIZE) ||
                       ((AWBURST_slvif == BURST_WRAP) && !wrap_len_ok(AWLEN_slvif));

    coreaxi4sram_burst_addr #(
        .AXI4_AWIDTH(AXI4_AWIDTH)
    ) u_burst_addr (
        .byte_addr (byte_addr),
        .size      (size_q),
        .burst     (burst_q),
        .wrap_mask (wrap_mask),
        .next_addr (next_addr)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (AWVALID_slvif && awready_q) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = ST_WDATA;
            ST_WDATA: if (w_beat && (beats_left == 8'd0)) state_nxt = ST_BRESP;
            ST_BRESP: if (BREADY_S) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!WR_EN) begin
            state_nxt = ST_IDLE;
        end
    end

    // awready is registered so it stays low while reset is applied.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= ST_IDLE;
            awready_q  <= 1'b0;
            byte_addr  <= '0;
            wrap_mask  <= '0;
            beats_left <= '0;
            size_q     <= '0;
            burst_q    <= BURST_FIXED;
            err        <= 1'b0;
            bid_mc     <= '0;
        end else begin
            state     <= state_nxt;
            awready_q <= WR_EN && (state_nxt == ST_IDLE);
            if (state == ST_SETUP) begin
                byte_addr  <= AWADDR_slvif;
                beats_left <= AWLEN_slvif;
                wrap_mask  <= ((AXI4_AWIDTH'(AWLEN_slvif) + ONE) << AWSIZE_slvif) - ONE;
                size_q     <= AWSIZE_slvif;
                burst_q    <= (AWBURST_slvif == BURST_RSVD) ? BURST_INCR : AWBURST_slvif;
                err        <= setup_err;
                bid_mc     <= AWID_slvif;
            end else if (w_beat) begin
                byte_addr  <= next_addr;
                beats_left <= beats_left - 8'd1;
                if (!in_range || wlast_bad) begin
                    err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_wben  <= '0;
        end else begin
            mem_we <= w_beat && in_range;
            if (w_beat) begin
                mem_waddr <= word_addr;
                mem_wdata <= WDATA_slvif;
                mem_wben  <= WSTRB_slvif;
            end
        end
    end

endmodule
